// File: rtl/arp_pkg.sv
// Constants, byte offsets and FSM state encoding for ARP frame generation and parsing.
// Offsets are measured from the first byte of the destination MAC address.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
    localparam logic [15:0] ARP_OP_REP     = 16'h0002;

    localparam logic [5:0] OFF_ETYPE     = 6'd12;
    localparam logic [5:0] OFF_OPER      = 6'd20;
    localparam logic [5:0] OFF_SHA       = 6'd22;
    localparam logic [5:0] OFF_SPA       = 6'd28;
    localparam logic [5:0] OFF_TPA       = 6'd38;
    localparam logic [5:0] ARP_FRAME_LEN = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } arp_state_t;

    // Fixed header bytes from the ethertype through the opcode of a request.
    function automatic logic [7:0] arp_req_hdr_byte(input logic [5:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            OFF_ETYPE:          b = ETH_TYPE_ARP[15:8];
            OFF_ETYPE + 6'd1:   b = ETH_TYPE_ARP[7:0];
            OFF_ETYPE + 6'd2:   b = ARP_HTYPE_ETH[15:8];
            OFF_ETYPE + 6'd3:   b = ARP_HTYPE_ETH[7:0];
            OFF_ETYPE + 6'd4:   b = ARP_PTYPE_IPV4[15:8];
            OFF_ETYPE + 6'd5:   b = ARP_PTYPE_IPV4[7:0];
            OFF_ETYPE + 6'd6:   b = 8'h06;
            OFF_ETYPE + 6'd7:   b = 8'h04;
            OFF_OPER:           b = ARP_OP_REQ[15:8];
            OFF_OPER + 6'd1:    b = ARP_OP_REQ[7:0];
            default:            b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arp_request_parser.sv
// Validates received ARP requests for LOCAL_IP and captures the requester SHA/SPA.
// Latency: req_valid rises one cycle after the committing eof beat.
// Backpressure: none on rx; a commit while a request is pending is dropped and counted.
module arp_request_parser
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_12_34_56_78_9A,
    parameter logic [31:0] LOCAL_IP  = {8'd10, 8'd10, 8'd10, 8'd100}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    output logic        req_valid,
    output logic [47:0] req_mac,
    output logic [31:0] req_ip,
    input  logic        req_ack,
    output logic [7:0]  drop_cnt
);

    arp_state_t  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        bcast_q, bcast_d;
    logic        ucast_q, ucast_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic        req_valid_q, req_valid_d;
    logic [47:0] req_mac_q, req_mac_d;
    logic [31:0] req_ip_q, req_ip_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic [5:0]  cur;
    logic [2:0]  mac_sel;
    logic [5:0]  tpa_off;
    logic [1:0]  ip_sel;
    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic        bc_hit;
    logic        uc_hit;
    logic        byte_ok;
    logic        active;
    logic        commit;

    // A sof beat is always byte 0, whatever idx held before.
    always_comb begin
        cur      = rx_sof ? 6'd0 : idx_q;
        mac_sel  = 3'd5 - cur[2:0];
        mac_byte = LOCAL_MAC[{mac_sel, 3'b000} +: 8];
        tpa_off  = cur - OFF_TPA;
        ip_sel   = 2'd3 - tpa_off[1:0];
        ip_byte  = LOCAL_IP[{ip_sel, 3'b000} +: 8];
        bc_hit   = ((cur == 6'd0) || bcast_q) && (rx_data == 8'hFF);
        uc_hit   = ((cur == 6'd0) || ucast_q) && (rx_data == mac_byte);
        if (cur < 6'd6) begin
            byte_ok = bc_hit || uc_hit;
        end else if ((cur >= OFF_ETYPE) && (cur < OFF_SHA)) begin
            byte_ok = (rx_data == arp_req_hdr_byte(cur));
        end else if ((cur >= OFF_TPA) && (cur < ARP_FRAME_LEN)) begin
            byte_ok = (rx_data == ip_byte);
        end else begin
            byte_ok = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            if (rx_sof) begin
                if (rx_eof) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = byte_ok ? ST_RECV : ST_DISCARD;
                end
            end else begin
                case (state_q)
                    ST_RECV: begin
                        if (rx_eof) begin
                            state_d = ST_IDLE;
                        end else if (!byte_ok) begin
                            state_d = ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (rx_eof) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        active = rx_valid && !rx_sof && (state_q == ST_RECV);
        commit = active && rx_eof && !rx_err && byte_ok
                 && (cur >= ARP_FRAME_LEN - 6'd1);
    end

    always_comb begin
        idx_d       = idx_q;
        bcast_d     = bcast_q;
        ucast_d     = ucast_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        req_valid_d = req_valid_q;
        req_mac_d   = req_mac_q;
        req_ip_d    = req_ip_q;
        drop_cnt_d  = drop_cnt_q;

        if (rx_valid) begin
            idx_d = (cur == ARP_FRAME_LEN) ? cur : cur + 6'd1;
            if (cur < 6'd6) begin
                bcast_d = bc_hit;
                ucast_d = uc_hit;
            end
        end
        if (active && (cur >= OFF_SHA) && (cur < OFF_SPA)) begin
            sha_d = {sha_q[39:0], rx_data};
        end
        if (active && (cur >= OFF_SPA) && (cur < OFF_SPA + 6'd4)) begin
            spa_d = {spa_q[23:0], rx_data};
        end

        // An ack coinciding with a commit frees the slot for the new request.
        if (commit) begin
            if (!req_valid_q || req_ack) begin
                req_valid_d = 1'b1;
                req_mac_d   = sha_q;
                req_ip_d    = spa_q;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (req_ack) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= 6'd0;
            bcast_q     <= 1'b0;
            ucast_q     <= 1'b0;
            sha_q       <= 48'd0;
            spa_q       <= 32'd0;
            req_valid_q <= 1'b0;
            req_mac_q   <= 48'd0;
            req_ip_q    <= 32'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            idx_q       <= idx_d;
            bcast_q     <= bcast_d;
            ucast_q     <= ucast_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            req_valid_q <= req_valid_d;
            req_mac_q   <= req_mac_d;
            req_ip_q    <= req_ip_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_mac   = req_mac_q;
    assign req_ip    = req_ip_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
